// File: rtl/exe_stage_pkg.sv
// Shared encodings for the MiniMIPS32 execute stage: instruction classes, operation
// codes, divider FSM states and stall levels.
package exe_stage_pkg;

   localparam int WORD_W    = 32;
   localparam int HILO_W    = 64;
   localparam int REG_AW    = 5;
   localparam int ALUOP_W   = 8;
   localparam int ALUTYPE_W = 3;

   typedef enum logic [ALUTYPE_W-1:0] {
      ALUTYPE_NOP   = 3'b000,
      ALUTYPE_ARITH = 3'b001,
      ALUTYPE_LOGIC = 3'b010,
      ALUTYPE_MOVE  = 3'b011,
      ALUTYPE_SHIFT = 3'b100,
      ALUTYPE_JUMP  = 3'b101
   } alutype_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam logic [ALUOP_W-1:0] MINIMIPS32_NOP   = 8'h00;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_LUI   = 8'h05;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MFHI  = 8'h0C;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MFLO  = 8'h0D;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MTHI  = 8'h0E;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MTLO  = 8'h0F;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SLL   = 8'h11;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SRL   = 8'h12;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SRA   = 8'h13;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MULT  = 8'h14;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_MULTU = 8'h15;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_DIV   = 8'h16;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_DIVU  = 8'h17;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_ADD   = 8'h18;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_ADDIU = 8'h19;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_ADDU  = 8'h1A;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SUBU  = 8'h1B;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_AND   = 8'h1C;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_ORI   = 8'h1D;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SUB   = 8'h1E;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_OR    = 8'h1F;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_XOR   = 8'h20;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_NOR   = 8'h21;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_ANDI  = 8'h22;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_XORI  = 8'h23;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SLT   = 8'h26;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SLTU  = 8'h27;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SLLV  = 8'h28;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SRLV  = 8'h29;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SRAV  = 8'h2A;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_J     = 8'h2C;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_JAL   = 8'h2D;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_JR    = 8'h2E;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_JALR  = 8'h2F;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_LB    = 8'h90;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_LW    = 8'h92;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SB    = 8'h98;
   localparam logic [ALUOP_W-1:0] MINIMIPS32_SW    = 8'h9A;

   // Two's-complement magnitude when neg is set, value unchanged otherwise.
   function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v, input logic neg);
      return neg ? (32'h0000_0000 - v) : v;
   endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider: one subtract-shift step per cycle over unsigned
// magnitudes, with sign fix-up applied to the quotient and remainder on the way out.
module exe_stage_div_iter
   import exe_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              signed_op,
   input  logic [WORD_W-1:0] dividend,
   input  logic [WORD_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] quot,
   output logic [WORD_W-1:0] rem
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   div_state_e        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [WORD_W-1:0] quot_r;
   logic [WORD_W-1:0] rem_r;
   logic [WORD_W-1:0] dvs_r;
   logic              neg_q_r;
   logic              neg_r_r;
   logic [WORD_W:0]   trial_s;
   logic [WORD_W-1:0] diff_s;
   logic              take_s;

   // The quotient register doubles as the dividend shifter; its MSB feeds the trial remainder.
   assign trial_s = {rem_r, quot_r[WORD_W-1]};
   assign take_s  = (trial_s >= {1'b0, dvs_r});
   assign diff_s  = trial_s[WORD_W-1:0] - dvs_r;

   // Divider FSM, iteration counter and partial remainder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= DIV_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         quot_r  <= 32'h0000_0000;
         rem_r   <= 32'h0000_0000;
         dvs_r   <= 32'h0000_0000;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (start) begin
                  if (divisor == 32'h0000_0000) begin
                     // Divide by zero: all-ones quotient, dividend as remainder, no fix-up.
                     quot_r  <= 32'hFFFF_FFFF;
                     rem_r   <= dividend;
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                     state_r <= DIV_DONE;
                  end else begin
                     quot_r  <= magnitude(dividend, signed_op & dividend[WORD_W-1]);
                     dvs_r   <= magnitude(divisor, signed_op & divisor[WORD_W-1]);
                     rem_r   <= 32'h0000_0000;
                     neg_q_r <= signed_op & (dividend[WORD_W-1] ^ divisor[WORD_W-1]);
                     neg_r_r <= signed_op & dividend[WORD_W-1];
                     cnt_r   <= {CNT_W{1'b0}};
                     state_r <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               quot_r <= {quot_r[WORD_W-2:0], take_s};
               rem_r  <= take_s ? diff_s : trial_s[WORD_W-1:0];
               if (cnt_r == CNT_LAST) begin
                  state_r <= DIV_DONE;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            DIV_DONE: state_r <= DIV_IDLE;
            default:  state_r <= DIV_IDLE;
         endcase
      end
   end

   assign busy = (state_r == DIV_BUSY);
   assign done = (state_r == DIV_DONE);
   assign quot = magnitude(quot_r, neg_q_r);
   assign rem  = magnitude(rem_r, neg_r_r);

endmodule

// File: rtl/exe_stage.sv
// MiniMIPS32 execute stage: combinational ALU/shift/move/jump-link/multiply with
// HI/LO forwarding, plus a multi-cycle divider that stalls the pipeline while it runs.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                 cpu_clk_50M,
   input  logic                 cpu_rst_n,
   input  logic [ALUTYPE_W-1:0] exe_alutype,
   input  logic [ALUOP_W-1:0]   exe_aluop,
   input  logic [WORD_W-1:0]    exe_src1,
   input  logic [WORD_W-1:0]    exe_src2,
   input  logic [WORD_W-1:0]    exe_din,
   input  logic [REG_AW-1:0]    exe_wa,
   input  logic                 exe_wreg,
   input  logic                 exe_whilo,
   input  logic                 exe_mreg,
   input  logic [WORD_W-1:0]    exe_retaddr,
   input  logic [WORD_W-1:0]    hi_i,
   input  logic [WORD_W-1:0]    lo_i,
   input  logic                 mem_whilo,
   input  logic [HILO_W-1:0]    mem_hilo,
   input  logic                 wb_whilo,
   input  logic [HILO_W-1:0]    wb_hilo,
   output logic [ALUOP_W-1:0]   exe_aluop_o,
   output logic [REG_AW-1:0]    exe_wa_o,
   output logic                 exe_wreg_o,
   output logic [WORD_W-1:0]    exe_wd_o,
   output logic                 exe_mreg_o,
   output logic [WORD_W-1:0]    exe_din_o,
   output logic                 exe_whilo_o,
   output logic [HILO_W-1:0]    exe_hilo_o,
   output logic                 stallreq_exe
);

   logic [WORD_W-1:0] hi_fwd_s, lo_fwd_s;
   logic [WORD_W-1:0] arith_s, logic_s, shift_s, move_s, wd_s;
   logic [HILO_W-1:0] mul_signed_s, mul_unsigned_s, hilo_s;
   logic [4:0]        shamt_s;
   logic              is_div_s, div_start_s, div_busy_s, div_done_s, whilo_s, stall_s;
   logic [WORD_W-1:0] div_quot_s, div_rem_s;

   // HI/LO forwarding: the younger MEM write beats WB, which beats the architectural copy.
   always_comb begin
      if (mem_whilo) begin
         {hi_fwd_s, lo_fwd_s} = mem_hilo;
      end else if (wb_whilo) begin
         {hi_fwd_s, lo_fwd_s} = wb_hilo;
      end else begin
         {hi_fwd_s, lo_fwd_s} = {hi_i, lo_i};
      end
   end

   // Arithmetic class, including load/store address generation.
   always_comb begin
      arith_s = 32'h0000_0000;
      case (exe_aluop)
         MINIMIPS32_ADD, MINIMIPS32_ADDU, MINIMIPS32_ADDIU,
         MINIMIPS32_LB, MINIMIPS32_LW, MINIMIPS32_SB, MINIMIPS32_SW:
            arith_s = exe_src1 + exe_src2;
         MINIMIPS32_SUB, MINIMIPS32_SUBU: arith_s = exe_src1 - exe_src2;
         MINIMIPS32_SLT:  arith_s = {31'h0, ($signed(exe_src1) < $signed(exe_src2))};
         MINIMIPS32_SLTU: arith_s = {31'h0, (exe_src1 < exe_src2)};
         default:         arith_s = 32'h0000_0000;
      endcase
   end

   // Logic class; immediates arrive pre-extended (LUI already shifted) in src2.
   always_comb begin
      logic_s = 32'h0000_0000;
      case (exe_aluop)
         MINIMIPS32_AND, MINIMIPS32_ANDI: logic_s = exe_src1 & exe_src2;
         MINIMIPS32_OR,  MINIMIPS32_ORI:  logic_s = exe_src1 | exe_src2;
         MINIMIPS32_XOR, MINIMIPS32_XORI: logic_s = exe_src1 ^ exe_src2;
         MINIMIPS32_NOR:                  logic_s = ~(exe_src1 | exe_src2);
         MINIMIPS32_LUI:                  logic_s = exe_src2;
         default:                         logic_s = 32'h0000_0000;
      endcase
   end

   assign shamt_s = exe_src1[4:0];

   // Shift class; src1 carries shamt or rs, so fixed and variable forms share a path.
   always_comb begin
      shift_s = 32'h0000_0000;
      case (exe_aluop)
         MINIMIPS32_SLL, MINIMIPS32_SLLV: shift_s = exe_src2 << shamt_s;
         MINIMIPS32_SRL, MINIMIPS32_SRLV: shift_s = exe_src2 >> shamt_s;
         MINIMIPS32_SRA, MINIMIPS32_SRAV: shift_s = $signed(exe_src2) >>> shamt_s;
         default:                         shift_s = 32'h0000_0000;
      endcase
   end

   // Move class reads the forwarded HI/LO.
   always_comb begin
      move_s = 32'h0000_0000;
      case (exe_aluop)
         MINIMIPS32_MFHI: move_s = hi_fwd_s;
         MINIMIPS32_MFLO: move_s = lo_fwd_s;
         default:         move_s = 32'h0000_0000;
      endcase
   end

   assign mul_signed_s   = {{32{exe_src1[WORD_W-1]}}, exe_src1} * {{32{exe_src2[WORD_W-1]}}, exe_src2};
   assign mul_unsigned_s = {32'h0000_0000, exe_src1} * {32'h0000_0000, exe_src2};

   assign is_div_s    = (exe_aluop == MINIMIPS32_DIV) || (exe_aluop == MINIMIPS32_DIVU);
   assign div_start_s = is_div_s & ~div_busy_s & ~div_done_s;

   exe_stage_div_iter #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_iter (
      .clk       (cpu_clk_50M),
      .rst_n     (cpu_rst_n),
      .start     (div_start_s),
      .signed_op (exe_aluop == MINIMIPS32_DIV),
      .dividend  (exe_src1),
      .divisor   (exe_src2),
      .busy      (div_busy_s),
      .done      (div_done_s),
      .quot      (div_quot_s),
      .rem       (div_rem_s)
   );

   // HI/LO write data; a divide only offers its result once the divider is done.
   always_comb begin
      hilo_s = 64'h0;
      case (exe_aluop)
         MINIMIPS32_MULT:  hilo_s = mul_signed_s;
         MINIMIPS32_MULTU: hilo_s = mul_unsigned_s;
         MINIMIPS32_MTHI:  hilo_s = {exe_src1, lo_fwd_s};
         MINIMIPS32_MTLO:  hilo_s = {hi_fwd_s, exe_src1};
         MINIMIPS32_DIV, MINIMIPS32_DIVU:
            hilo_s = div_done_s ? {div_rem_s, div_quot_s} : 64'h0;
         default:          hilo_s = 64'h0;
      endcase
   end

   // GPR write data by instruction class.
   always_comb begin
      wd_s = 32'h0000_0000;
      case (exe_alutype)
         ALUTYPE_ARITH: wd_s = arith_s;
         ALUTYPE_LOGIC: wd_s = logic_s;
         ALUTYPE_MOVE:  wd_s = move_s;
         ALUTYPE_SHIFT: wd_s = shift_s;
         ALUTYPE_JUMP:  wd_s = exe_retaddr;
         default:       wd_s = 32'h0000_0000;
      endcase
   end

   assign whilo_s = is_div_s ? (exe_whilo & div_done_s) : exe_whilo;
   assign stall_s = (div_start_s | div_busy_s) ? STOP : NOSTOP;

   assign exe_aluop_o  = cpu_rst_n ? exe_aluop   : 8'h00;
   assign exe_wa_o     = cpu_rst_n ? exe_wa      : 5'd0;
   assign exe_wreg_o   = cpu_rst_n ? exe_wreg    : 1'b0;
   assign exe_wd_o     = cpu_rst_n ? wd_s        : 32'h0000_0000;
   assign exe_mreg_o   = cpu_rst_n ? exe_mreg    : 1'b0;
   assign exe_din_o    = cpu_rst_n ? exe_din     : 32'h0000_0000;
   assign exe_whilo_o  = cpu_rst_n ? whilo_s     : 1'b0;
   assign exe_hilo_o   = cpu_rst_n ? hilo_s      : 64'h0;
   assign stallreq_exe = cpu_rst_n ? stall_s     : NOSTOP;

endmodule
